usr_seq: RTL and testbench

Parametrised universal shift register with WIDTH bits and eight operating modes: hold, logical shift, rotate, arithmetic shift and parallel load.
It also contains a burst sequencer. One start pulse applies a shift/rotate mode a programmed number of times, then signals completion.
It is the datapath primitive for serialisers, barrel-free multi-bit shifts and bit-stream generators in the digital-implementations library.

---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr_next_val.sv | 30 +++
 rtl/usr_seq.sv | 105 ++++++++++
 tb/tb_usr_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode and state encodings for the universal shift register and its burst sequencer.
// Pure definitions: no logic, no latency, no flow control.
// Imported by usr_next_val and usr_seq.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Only moving operations are worth repeating; hold/load/reserved complete in one edge.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_next_val.sv
// Next-value mux for the shift register: selects shift/rotate/load/hold result for a mode.
// Purely combinational, zero latency; no flow control.
// Serial inputs are consumed whenever the caller registers the result.
module usr_next_val
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             msb_in_i,
    input  logic             lsb_in_i,
    output logic [WIDTH-1:0] nxt_o
);

    always_comb begin
        nxt_o = q_i;
        case (mode_i)
            MODE_SHR:  nxt_o = {msb_in_i, q_i[WIDTH-1:1]};
            MODE_SHL:  nxt_o = {q_i[WIDTH-2:0], lsb_in_i};
            MODE_LOAD: nxt_o = din_i;
            MODE_ROR:  nxt_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ROL:  nxt_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ASR:  nxt_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default:   nxt_o = q_i;
        endcase
    end

endmodule

// File: rtl/usr_seq.sv
// Universal shift register with a burst sequencer repeating one operation count times.
// Direct ops take effect at the next edge; a burst takes count enabled edges, done one cycle later.
// en low stalls a running burst in place; start while busy is dropped.
module usr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sync_clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] nxt;

    // A running burst uses its latched mode; live mode is only honoured in IDLE.
    assign op_mode = (state_q == ST_RUN) ? mode_q : mode;

    usr_next_val #(.WIDTH(WIDTH)) u_next (
        .q_i      (q_q),
        .mode_i   (op_mode),
        .din_i    (din),
        .msb_in_i (msb_in),
        .lsb_in_i (lsb_in),
        .nxt_o    (nxt)
    );

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (sync_clr) begin
            q_d     = '0;
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                mode_d = mode;
                if (count == '0) begin
                    done_d = 1'b1;
                end else if (!is_burst_mode(mode) || count == CNT_W'(1)) begin
                    q_d    = nxt;
                    done_d = 1'b1;
                end else begin
                    q_d     = nxt;
                    rem_d   = count - CNT_W'(1);
                    state_d = ST_RUN;
                end
            end else if (en) begin
                q_d = nxt;
            end
        end else if (en) begin
            q_d   = nxt;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q     <= '0;
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign q         = q_q;
    assign ser_out_r = q_q[0];
    assign ser_out_l = q_q[WIDTH-1];
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_usr_seq.sv
// Self-checking bench for usr_seq: directed scenarios followed by randomized traffic.
// Expected values come from an arithmetic reference model of the register and burst rules.
module tb_usr_seq;

    localparam int W  = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          clear_n, sync_clr, en, msb_in, lsb_in, start;
    logic [2:0]    mode;
    logic [W-1:0]  din;
    logic [CW-1:0] count;
    logic [W-1:0]  q;
    logic          ser_out_r, ser_out_l, busy, done;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [W-1:0] m_q    = '0;
    int           m_ops  = 0;
    logic [2:0]   m_mode = '0;
    logic         m_done = 1'b0;

    always #5 clk = ~clk;

    usr_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .sync_clr  (sync_clr),
        .en        (en),
        .mode      (mode),
        .din       (din),
        .msb_in    (msb_in),
        .lsb_in    (lsb_in),
        .start     (start),
        .count     (count),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] apply(input logic [2:0] md, input logic [W-1:0] v,
                                           input logic [W-1:0] d, input logic mi, input logic li);
        int iv;
        int x;
        iv = int'(v);
        case (md)
            3'd1:    x = iv / 2 + (mi ? 128 : 0);
            3'd2:    x = (iv * 2) % 256 + (li ? 1 : 0);
            3'd3:    x = int'(d);
            3'd4:    x = iv / 2 + (iv % 2) * 128;
            3'd5:    x = (iv * 2) % 256 + iv / 128;
            3'd6:    x = iv / 2 + (iv >= 128 ? 128 : 0);
            default: x = iv;
        endcase
        return x[W-1:0];
    endfunction

    function automatic bit repeats(input logic [2:0] md);
        return md inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    endfunction

    task automatic model_edge();
        logic nd;
        nd = 1'b0;
        if (sync_clr) begin
            m_q   = '0;
            m_ops = 0;
        end else if (m_ops > 0) begin
            if (en) begin
                m_q = apply(m_mode, m_q, din, msb_in, lsb_in);
                m_ops--;
                if (m_ops == 0) nd = 1'b1;
            end
        end else if (start) begin
            m_mode = mode;
            if (count != 0) begin
                m_q = apply(mode, m_q, din, msb_in, lsb_in);
                if (repeats(mode)) m_ops = int'(count) - 1;
            end
            if (m_ops == 0) nd = 1'b1;
        end else if (en) begin
            m_q = apply(mode, m_q, din, msb_in, lsb_in);
        end
        m_done = nd;
    endtask

    task automatic model_reset();
        m_q    = '0;
        m_ops  = 0;
        m_done = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("q", q, m_q);
        chk("busy", busy, (m_ops > 0));
        chk("done", done, m_done);
        chk("taps", {ser_out_l, ser_out_r}, {m_q[W-1], m_q[0]});
    endtask

    task automatic drive(input logic e, input logic [2:0] md, input logic [W-1:0] d,
                         input logic mi, input logic li, input logic st, input logic [CW-1:0] c);
        en = e; mode = md; din = d; msb_in = mi; lsb_in = li; start = st; count = c;
    endtask

    task automatic async_reset();
        #2 clear_n = 1'b0;
        model_reset();
        #1;
        chk("arst_q", q, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        #2 clear_n = 1'b1;
    endtask

    initial begin
        clear_n = 1'b0; sync_clr = 1'b0;
        drive(0, 3'd0, 8'h00, 0, 0, 0, 5'd0);
        #12;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #1 clear_n = 1'b1;

        // async reset in the middle of a RUN burst
        drive(1, 3'd3, 8'h81, 0, 0, 0, 5'd0); step();
        drive(1, 3'd5, 8'h00, 0, 0, 1, 5'd5); step();
        chk("t1_busy", busy, 1);
        drive(1, 3'd5, 8'h00, 0, 0, 0, 5'd5); step();
        async_reset();
        drive(0, 3'd0, 8'h00, 0, 0, 0, 5'd0); step(); step();
        chk("t1_nodone", done, 0);

        // direct mode sequence
        drive(1, 3'd3, 8'hA5, 0, 0, 0, 5'd0); step(); chk("t2_load", q, 8'hA5);
        drive(1, 3'd1, 8'h00, 1, 0, 0, 5'd0); step(); chk("t2_shr", q, 8'hD2);
        drive(1, 3'd2, 8'h00, 0, 0, 0, 5'd0); step(); chk("t2_shl", q, 8'hA4);
        drive(1, 3'd0, 8'h00, 0, 0, 0, 5'd0); step(); chk("t2_hold", q, 8'hA4);
        drive(0, 3'd1, 8'h00, 1, 0, 0, 5'd0); step(); chk("t2_en0", q, 8'hA4);

        // arithmetic shift right keeps the sign bit
        drive(1, 3'd3, 8'h80, 0, 0, 0, 5'd0); step();
        drive(1, 3'd6, 8'h00, 0, 0, 0, 5'd0);
        step(); chk("t3_asr1", q, 8'hC0); chk("t3_sl1", ser_out_l, 1);
        step(); chk("t3_asr2", q, 8'hE0); chk("t3_sl2", ser_out_l, 1);
        step(); chk("t3_asr3", q, 8'hF0); chk("t3_sl3", ser_out_l, 1);

        // ROL burst of 3, with a start attempted while busy
        drive(1, 3'd3, 8'h81, 0, 0, 0, 5'd0); step();
        drive(1, 3'd5, 8'h00, 0, 0, 1, 5'd3); step(); chk("t4_q1", q, 8'h03); chk("t4_b1", busy, 1);
        drive(1, 3'd0, 8'h00, 0, 0, 0, 5'd0); step(); chk("t4_q2", q, 8'h06); chk("t4_b2", busy, 1);
        drive(1, 3'd3, 8'hFF, 0, 0, 1, 5'd7); step(); chk("t4_q3", q, 8'h0C); chk("t4_done", done, 1);
        drive(0, 3'd0, 8'h00, 0, 0, 0, 5'd0); step(); chk("t4_q4", q, 8'h0C); chk("t4_done0", done, 0);

        // boundary counts
        drive(1, 3'd4, 8'h00, 0, 0, 1, 5'd0); step();
        chk("t5_c0_q", q, 8'h0C); chk("t5_c0_done", done, 1); chk("t5_c0_busy", busy, 0);
        drive(1, 3'd3, 8'h01, 0, 0, 0, 5'd0); step();
        drive(1, 3'd4, 8'h00, 0, 0, 1, 5'd10); step();
        drive(1, 3'd0, 8'h00, 0, 0, 0, 5'd0);
        for (int i = 0; i < 20 && m_ops > 0; i++) step();
        chk("t5_c10_end", busy, 0);
        chk("t5_c10_q", q, 8'h40);
        drive(1, 3'd5, 8'h00, 0, 0, 1, 5'd1); step();
        chk("t5_c1_busy", busy, 0); chk("t5_c1_done", done, 1); chk("t5_c1_q", q, 8'h80);

        // stall mid-run, then abort with sync_clr
        drive(1, 3'd3, 8'hF0, 0, 0, 0, 5'd0); step();
        drive(1, 3'd1, 8'h00, 0, 0, 1, 5'd4); step();
        drive(1, 3'd0, 8'h00, 0, 0, 0, 5'd0); step();
        drive(0, 3'd0, 8'h00, 0, 0, 0, 5'd0); step(); step(); chk("t6_stall_busy", busy, 1);
        drive(1, 3'd0, 8'h00, 0, 0, 0, 5'd0); step(); step();
        chk("t6_q", q, 8'h0F); chk("t6_done", done, 1);
        drive(1, 3'd3, 8'hF0, 0, 0, 0, 5'd0); step();
        drive(1, 3'd1, 8'h00, 0, 0, 1, 5'd4); step();
        drive(1, 3'd0, 8'h00, 0, 0, 0, 5'd0); sync_clr = 1'b1; step();
        chk("t6_abort_q", q, 0); chk("t6_abort_busy", busy, 0);
        sync_clr = 1'b0; step(); chk("t6_abort_done", done, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(3) != 0), 3'($urandom_range(7)), 8'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(7) == 0), 5'($urandom_range(20)));
            sync_clr = ($urandom_range(40) == 0);
            if ($urandom_range(150) == 0) async_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
